// File: rtl/sram_ctrl.sv
// Shares a 16-bit SRAM with the memory stage: each 32-bit word is two half-word accesses, ready low until done.
// Optional one-entry write-through read cache when SRAM_CTRL_CACHE_EN is defined.
module sram_ctrl #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_is_wr;
    logic [16:0] r_w;
    logic [31:0] r_wdata;
    logic [15:0] r_hold_lo;
    logic [31:0] r_read_data;
    logic [17:0] r_sram_addr;
    logic        r_we_n;
    logic        r_dq_oe;
    logic [15:0] r_dq_out;

    logic        w_req;
    logic        w_last;
    logic        w_hit;
    logic [16:0] w_word;

    assign w_req  = rd_en | wr_en;
    assign w_word = 17'((address - BASE_ADDR) >> 2);
    assign w_last = (r_cnt == 3'(WAIT_CYCLES));

`ifdef SRAM_CTRL_CACHE_EN
    logic        r_c_vld;
    logic [16:0] r_c_tag;
    logic [31:0] r_c_data;

    // A simultaneous write wins, so only a pure read may hit.
    assign w_hit = rd_en & ~wr_en & r_c_vld & (r_c_tag == w_word);
`else
    assign w_hit = 1'b0;
`endif

    assign ready     = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
    assign read_data = r_read_data;
    assign SRAM_ADDR = r_sram_addr;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_DQ   = r_dq_oe ? r_dq_out : 16'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_is_wr     <= 1'b0;
            r_w         <= 17'd0;
            r_wdata     <= 32'd0;
            r_hold_lo   <= 16'd0;
            r_read_data <= 32'd0;
            r_sram_addr <= 18'd0;
            r_we_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= 16'd0;
`ifdef SRAM_CTRL_CACHE_EN
            r_c_vld     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 3'd0;
                    if (w_hit) begin
`ifdef SRAM_CTRL_CACHE_EN
                        r_read_data <= r_c_data;
`endif
                        r_state <= S_DONE;
                    end else if (w_req) begin
                        r_is_wr     <= wr_en;
                        r_w         <= w_word;
                        r_wdata     <= write_data;
                        r_sram_addr <= {w_word, 1'b0};
                        r_we_n      <= ~wr_en;
                        r_dq_oe     <= wr_en;
                        r_dq_out    <= write_data[15:0];
                        r_state     <= S_LO;
`ifdef SRAM_CTRL_CACHE_EN
                        if (wr_en) begin
                            r_c_vld  <= 1'b1;
                            r_c_tag  <= w_word;
                            r_c_data <= write_data;
                        end
`endif
                    end
                end
                S_LO: begin
                    if (w_last) begin
                        if (!r_is_wr) r_hold_lo <= SRAM_DQ;
                        r_sram_addr <= {r_w, 1'b1};
                        r_dq_out    <= r_wdata[31:16];
                        r_cnt       <= 3'd0;
                        r_state     <= S_HI;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_HI: begin
                    if (w_last) begin
                        if (!r_is_wr) begin
                            r_read_data <= {SRAM_DQ, r_hold_lo};
`ifdef SRAM_CTRL_CACHE_EN
                            r_c_vld  <= 1'b1;
                            r_c_tag  <= r_w;
                            r_c_data <= {SRAM_DQ, r_hold_lo};
`endif
                        end
                        r_we_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                        r_cnt   <= 3'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    r_cnt   <= 3'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
